instr_mem_fetch: RTL and testbench

Parametrised, writable instruction memory with a registered, handshaked fetch port. It replaces fixed per-program instruction tables, so the same core can run the product, string-match and closest-pair programs from one loadable store. The write port loads the store. The fetch side feeds the decode stage through a small response queue that supports back-pressure and branch flush.

---
 rtl/instr_mem_fetch.sv | 151 +++++++++++++++
 tb/tb_instr_mem_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_fetch.sv
// Writable instruction store with a handshaked fetch port, 1-cycle read latency and a small response queue.
// Optional macro INSTR_PARITY_EN adds a stored even-parity bit per entry and the rsp_perr / wr_perr_inj ports.
module instr_mem_fetch #(
    parameter int INST_W    = 20,
    parameter int ADDR_W    = 9,
    parameter int DEPTH     = 512,
    parameter int RSP_DEPTH = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [INST_W-1:0] wr_data,
`ifdef INSTR_PARITY_EN
    input  logic              wr_perr_inj,
    output logic              rsp_perr,
`endif
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              rsp_valid,
    output logic [INST_W-1:0] rsp_inst,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    input  logic              rsp_ready
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CW:0] RSP_LIM = (CW + 1)'(RSP_DEPTH);
`ifdef INSTR_PARITY_EN
    localparam int MW = INST_W + 1;
`else
    localparam int MW = INST_W;
`endif

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
        logic              err;
`ifdef INSTR_PARITY_EN
        logic              perr;
`endif
    } rsp_t;

    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [MW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] wbit;

    logic             wr_ok, req_in, accept;
    logic [MW-1:0]    wr_word;
    rsp_t             rd;

    logic             stg_vld;
    rsp_t             stg;
    rsp_t             q [RSP_DEPTH];
    logic [PW-1:0]    rptr, wptr;
    logic [CW-1:0]    count;
    logic             q_ne, pop, pop_q, push;
    rsp_t             head;

    assign wr_ok  = wr_en && (32'(wr_addr) < DEPTH);
    assign req_in = 32'(req_addr) < DEPTH;

`ifdef INSTR_PARITY_EN
    // Stored bit makes the whole word even; the inject input flips it.
    assign wr_word = {(^wr_data) ^ wr_perr_inj, wr_data};
`else
    assign wr_word = wr_data;
`endif

    always_ff @(posedge Clk) begin
        if (wr_ok)
            mem[wr_addr] <= wr_word;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n)
            wbit <= '0;
        else if (wr_ok)
            wbit[wr_addr] <= 1'b1;
    end

    // Write-first read; unwritten entries look like the all-zero NOP.
    always_comb begin
        rd      = '0;
        rd.addr = req_addr;
        rd.err  = !req_in;
        if (req_in) begin
            if (wr_ok && (wr_addr == req_addr)) begin
                rd.inst = wr_data;
`ifdef INSTR_PARITY_EN
                rd.perr = wr_perr_inj;
`endif
            end else if (wbit[req_addr]) begin
                rd.inst = mem[req_addr][INST_W-1:0];
`ifdef INSTR_PARITY_EN
                rd.perr = ^mem[req_addr];
`endif
            end
        end
    end

    // The stage register doubles as the head when the queue is empty, giving 1-cycle latency.
    assign q_ne      = (count != '0);
    assign rsp_valid = q_ne || stg_vld;
    assign head      = q_ne ? q[rptr] : stg;
    assign pop       = rsp_valid && rsp_ready;
    assign pop_q     = pop && q_ne;
    assign push      = stg_vld && !(pop && !q_ne);

    assign req_ready = Reset_n && !flush &&
                       (({1'b0, count} + {{CW{1'b0}}, stg_vld}) < RSP_LIM);
    assign accept    = req_valid && req_ready;

    assign rsp_inst = rsp_valid ? head.inst : '0;
    assign rsp_addr = rsp_valid ? head.addr : '0;
    assign rsp_err  = rsp_valid ? head.err  : 1'b0;
`ifdef INSTR_PARITY_EN
    assign rsp_perr = rsp_valid ? head.perr : 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset_n && !flush && push)
            q[wptr] <= stg;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n || flush) begin
            stg_vld <= 1'b0;
            stg     <= '0;
            rptr    <= '0;
            wptr    <= '0;
            count   <= '0;
        end else begin
            stg_vld <= accept;
            if (accept)
                stg <= rd;
            if (push)
                wptr <= ptr_nxt(wptr);
            if (pop_q)
                rptr <= ptr_nxt(rptr);
            count <= count + CW'(push) - CW'(pop_q);
        end
    end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch (DEPTH=300): expected responses are queued at issue and
// compared by a monitor on each delivered response.
module tb_instr_mem_fetch;

    localparam int INST_W = 20;
    localparam int ADDR_W = 9;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [INST_W-1:0] wr_data;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              flush;
    logic              rsp_valid;
    logic [INST_W-1:0] rsp_inst;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_err;
    logic              rsp_ready;
`ifdef INSTR_PARITY_EN
    logic              wr_perr_inj;
    logic              rsp_perr;
`endif

    instr_mem_fetch #(.INST_W(INST_W), .ADDR_W(ADDR_W), .DEPTH(300), .RSP_DEPTH(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef INSTR_PARITY_EN
        .wr_perr_inj(wr_perr_inj), .rsp_perr(rsp_perr),
`endif
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_inst(rsp_inst), .rsp_addr(rsp_addr),
        .rsp_err(rsp_err), .rsp_ready(rsp_ready)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Monitor: every handshaken response is compared against the oldest expectation.
    always @(negedge Clk) begin
        if (Reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_rsp: got addr %h inst %h, expected none", rsp_addr, rsp_inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_addr", 32'(rsp_addr), 32'(e.addr));
                check("rsp_inst", 32'(rsp_inst), 32'(e.inst));
                check("rsp_err",  32'(rsp_err),  32'(e.err));
`ifdef INSTR_PARITY_EN
                check("rsp_perr", 32'(rsp_perr), 32'(0));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [INST_W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Presents one request for one cycle; queues the expectation only if it was accepted.
    task automatic issue(input logic [ADDR_W-1:0] a, input logic [INST_W-1:0] ei,
                         input logic ee, output bit acc);
        req_valid = 1'b1; req_addr = a;
        @(negedge Clk);
        acc = req_ready;
        if (acc) exp_q.push_back('{inst: ei, addr: a, err: ee});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge Clk);
            n++;
        end
        #1;
        check("drain_left", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit acc;
        Reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b1;
`ifdef INSTR_PARITY_EN
        wr_perr_inj = 1'b0;
`endif
        tick();
        @(negedge Clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_inst",  32'(rsp_inst),  32'(0));
        check("rst_rsp_addr",  32'(rsp_addr),  32'(0));
        check("rst_rsp_err",   32'(rsp_err),   32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        tick();
        Reset_n = 1'b1;

        wr(9'd0, 20'hE0000);
        wr(9'd1, 20'h60A20);
        wr(9'd2, 20'hA0002);
        wr(9'd3, 20'hB0003);
        wr(9'd4, 20'hC0004);
        wr(9'd300, 20'hABCDE);

        // Back-to-back fetch of 0,1 with 1-cycle latency.
        issue(9'd0, 20'hE0000, 1'b0, acc);
        check("acc0", 32'(acc), 32'(1));
        req_valid = 1'b1; req_addr = 9'd1;
        @(negedge Clk);
        check("lat_n1_valid", 32'(rsp_valid), 32'(1));
        check("lat_n1_addr",  32'(rsp_addr),  32'(0));
        check("acc1", 32'(req_ready), 32'(1));
        if (req_ready) exp_q.push_back('{inst: 20'h60A20, addr: 9'd1, err: 1'b0});
        tick();
        req_valid = 1'b0;
        @(negedge Clk);
        check("lat_n2_valid", 32'(rsp_valid), 32'(1));
        check("lat_n2_addr",  32'(rsp_addr),  32'(1));
        drain();

        // Unwritten last entry, out-of-range (ignored write at 300), far out-of-range.
        issue(9'd299,   20'h0, 1'b0, acc);
        issue(9'd300,   20'h0, 1'b1, acc);
        issue(9'h1FF,   20'h0, 1'b1, acc);
        check("acc_oor", 32'(acc), 32'(1));
        drain();

        // Write-first read in the accept cycle, then a plain re-read.
        wr_en = 1'b1; wr_addr = 9'd5; wr_data = 20'h12345;
        issue(9'd5, 20'h12345, 1'b0, acc);
        wr_en = 1'b0;
        issue(9'd5, 20'h12345, 1'b0, acc);
        drain();

        // Back-pressure: only two requests fit.
        rsp_ready = 1'b0;
        issue(9'd2, 20'hA0002, 1'b0, acc);
        check("bp_acc2", 32'(acc), 32'(1));
        issue(9'd3, 20'hB0003, 1'b0, acc);
        check("bp_acc3", 32'(acc), 32'(1));
        issue(9'd4, 20'hC0004, 1'b0, acc);
        check("bp_acc4_blocked", 32'(acc), 32'(0));
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            check("bp_head_addr", 32'(rsp_addr),  32'(2));
            check("bp_head_inst", 32'(rsp_inst),  32'(20'hA0002));
            check("bp_req_ready", 32'(req_ready), 32'(0));
            tick();
        end
        rsp_ready = 1'b1;
        issue(9'd4, 20'hC0004, 1'b0, acc);
        check("bp_release_full", 32'(acc), 32'(0));
        issue(9'd4, 20'hC0004, 1'b0, acc);
        check("bp_release_acc4", 32'(acc), 32'(1));
        drain();

        // Flush with one queued entry and one in flight.
        rsp_ready = 1'b0;
        issue(9'd0, 20'hE0000, 1'b0, acc);
        issue(9'd1, 20'h60A20, 1'b0, acc);
        flush = 1'b1; req_valid = 1'b1; req_addr = 9'd2;
        @(negedge Clk);
        check("flush_req_ready", 32'(req_ready), 32'(0));
        check("pre_flush_valid", 32'(rsp_valid), 32'(1));
        tick();
        flush = 1'b0; req_valid = 1'b0;
        exp_q.delete();
        @(negedge Clk);
        check("post_flush_valid", 32'(rsp_valid), 32'(0));
        check("post_flush_ready", 32'(req_ready), 32'(1));
        tick();
        rsp_ready = 1'b1;
        issue(9'd2, 20'hA0002, 1'b0, acc);
        drain();

        // Reset mid-stream with the queue full.
        rsp_ready = 1'b0;
        issue(9'd0, 20'hE0000, 1'b0, acc);
        issue(9'd1, 20'h60A20, 1'b0, acc);
        tick();
        Reset_n = 1'b0;
        @(negedge Clk);
        check("rst2_req_ready", 32'(req_ready), 32'(0));
        tick();
        Reset_n = 1'b1;
        exp_q.delete();
        @(negedge Clk);
        check("rst2_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst2_rsp_inst",  32'(rsp_inst),  32'(0));
        check("rst2_rsp_addr",  32'(rsp_addr),  32'(0));
        check("rst2_rsp_err",   32'(rsp_err),   32'(0));
        tick();
        rsp_ready = 1'b1;
        issue(9'd0, 20'h0, 1'b0, acc);
        issue(9'd5, 20'h0, 1'b0, acc);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
